// File: rtl/fp_pkg.sv
// Shared fp32 field widths, special encodings and accumulator FSM states
// for the systolic PE accumulator.
package fp_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [31:0]         FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0]         FP_QNAN     = 32'h7FC0_0000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} accum_state_e;

  // Subnormals flush to zero, so exp==0 contributes no mantissa at all.
  function automatic logic [FP_MAN_W:0] fp_mant24(input fp32_t v);
    return (v.exp == '0) ? '0 : {1'b1, v.man};
  endfunction
endpackage

// File: rtl/fp_accum_if.sv
// Operand-in / result-out bus of the fp32 accumulator.
// A beat transfers on a clock edge where valid && ready; the sender holds
// data/last stable while valid is high and ready is low, and valid never
// waits on ready.
interface fp_accum_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp_lzc24.sv
// Combinational leading-zero counter over a 24-bit mantissa; returns 24 when
// the input is all zero.
module fp_lzc24 (
  input  logic [23:0] val_i,
  output logic [4:0]  lzc_o
);
  always_comb begin
    lzc_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (val_i[i]) lzc_o = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_accum.sv
// Multi-cycle fp32 run accumulator: IDLE -> ALIGN -> ADD -> NORM per operand,
// DONE holds the finished dot product until the consumer takes it.
module fp_accum
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  fp_accum_if.slave    bus,
  output accum_state_e state_o
);
  accum_state_e     state_q;
  fp32_t            acc_q, opnd_q;
  logic             last_q, in_ready_q, out_valid_q;
  logic [31:0]      out_data_q, special_val_q;
  logic [CNT_W-1:0] count_q, out_count_q;
  logic             big_sign_q, sub_q, special_q;
  logic [7:0]       big_exp_q;
  logic [23:0]      big_man_q, small_man_q;
  logic [24:0]      sum_q;

  // ALIGN: order operands by magnitude and resolve special values.
  fp32_t       big_d, small_d;
  logic [7:0]  exp_diff_d;
  logic [23:0] small_shift_d;
  logic        a_nan, b_nan, a_inf, b_inf, special_d;
  logic [31:0] special_val_d;

  always_comb begin
    if ({opnd_q.exp, opnd_q.man} > {acc_q.exp, acc_q.man}) begin
      big_d   = opnd_q;
      small_d = acc_q;
    end else begin
      big_d   = acc_q;
      small_d = opnd_q;
    end
    exp_diff_d    = big_d.exp - small_d.exp;
    small_shift_d = (exp_diff_d >= 8'd25) ? 24'h0 : (fp_mant24(small_d) >> exp_diff_d);

    a_nan = (acc_q.exp == FP_EXP_MAX) && (acc_q.man != '0);
    b_nan = (opnd_q.exp == FP_EXP_MAX) && (opnd_q.man != '0);
    a_inf = (acc_q.exp == FP_EXP_MAX) && (acc_q.man == '0);
    b_inf = (opnd_q.exp == FP_EXP_MAX) && (opnd_q.man == '0);
    special_d = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan)                                 special_val_d = FP_QNAN;
    else if (a_inf && b_inf && (acc_q.sign != opnd_q.sign)) special_val_d = FP_QNAN;
    else if (a_inf)                                     special_val_d = acc_q;
    else                                                special_val_d = opnd_q;
  end

  // NORM: renormalise the 25-bit sum, truncating and saturating.
  logic [4:0]        lzc;
  logic signed [9:0] norm_exp;
  logic [23:0]       norm_man;
  fp32_t             norm_res;

  fp_lzc24 u_lzc (.val_i(sum_q[23:0]), .lzc_o(lzc));

  always_comb begin
    norm_exp = '0;
    norm_man = sum_q[23:0];
    if (sum_q[24]) begin
      norm_exp = $signed({2'b00, big_exp_q}) + 10'sd1;
      norm_man = sum_q[24:1];
    end else if (sum_q != '0) begin
      norm_exp = $signed({2'b00, big_exp_q}) - $signed({5'b00000, lzc});
      norm_man = sum_q[23:0] << lzc;
    end
    if (special_q)                              norm_res = special_val_q;
    else if ((sum_q == '0) || (norm_exp <= 0))  norm_res = FP_POS_ZERO;
    else if (norm_exp >= 10'sd255)              norm_res = {big_sign_q, FP_EXP_MAX, 23'h0};
    else                                        norm_res = {big_sign_q, norm_exp[7:0], norm_man[22:0]};
  end

  logic [CNT_W-1:0] count_inc;
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= FP_POS_ZERO;
      opnd_q        <= FP_POS_ZERO;
      last_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_count_q   <= '0;
      count_q       <= '0;
      big_sign_q    <= 1'b0;
      big_exp_q     <= '0;
      big_man_q     <= '0;
      small_man_q   <= '0;
      sub_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      sum_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid && in_ready_q) begin
          opnd_q     <= bus.in_data;
          last_q     <= bus.in_last;
          in_ready_q <= 1'b0;
          state_q    <= ALIGN;
        end
        ALIGN: begin
          big_sign_q    <= big_d.sign;
          big_exp_q     <= big_d.exp;
          big_man_q     <= fp_mant24(big_d);
          small_man_q   <= small_shift_d;
          sub_q         <= big_d.sign ^ small_d.sign;
          special_q     <= special_d;
          special_val_q <= special_val_d;
          state_q       <= special_d ? NORM : ADD;
        end
        ADD: begin
          sum_q   <= sub_q ? ({1'b0, big_man_q} - {1'b0, small_man_q})
                           : ({1'b0, big_man_q} + {1'b0, small_man_q});
          state_q <= NORM;
        end
        NORM: begin
          acc_q   <= norm_res;
          count_q <= count_inc;
          if (last_q) begin
            out_data_q  <= norm_res;
            out_count_q <= count_inc;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          acc_q       <= FP_POS_ZERO;
          count_q     <= '0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: runs of fp32 products with a result scoreboard,
// handshake timing, backpressure and mid-run reset.
module tb_fp_accum;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_accum_if #(.CNT_W(16)) bus ();
  accum_state_e state;

  fp_accum #(.CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt_q[$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_result(input logic [31:0] d, input logic [15:0] c);
    exp_q.push_back(d);
    exp_cnt_q.push_back(c);
  endtask

  // Waits for in_ready, transfers one operand; when timed, checks the
  // 3-cycle busy window and then ready (non-last) or out_valid (last).
  task automatic send(input logic [31:0] d, input logic last, input bit timed);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check32("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (timed) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (last) check32("out_valid_early", 32'(bus.out_valid), 32'd0);
        else      check32("in_ready_busy", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      if (last) check32("out_valid_rise", 32'(bus.out_valid), 32'd1);
      else      check32("in_ready_back", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic collect();
    int n = 0;
    logic [31:0] e_d;
    logic [15:0] e_c;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check32("out_valid_wait", 32'(bus.out_valid), 32'd1);
    e_d = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    e_c = (exp_cnt_q.size() != 0) ? exp_cnt_q.pop_front() : 16'hFFFF;
    check32("out_data", bus.out_data, e_d);
    check32("out_count", 32'(bus.out_count), 32'(e_c));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check32("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check32("in_ready_after_out", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check32("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check32("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check32("rst_out_data", bus.out_data, 32'h0);
    check32("rst_out_count", 32'(bus.out_count), 32'd0);
    check32("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;

    // Single element with last
    expect_result(32'h4040_0000, 16'd1);
    send(32'h4040_0000, 1'b1, 1'b1);
    collect();

    // 1.0 + 2.0 + 3.0
    expect_result(32'h40C0_0000, 16'd3);
    send(32'h3F80_0000, 1'b0, 1'b1);
    send(32'h4000_0000, 1'b0, 1'b1);
    send(32'h4040_0000, 1'b1, 1'b1);
    collect();

    // Exact cancellation
    expect_result(32'h0000_0000, 16'd2);
    send(32'h4040_0000, 1'b0, 1'b1);
    send(32'hC040_0000, 1'b1, 1'b1);
    collect();

    // 1.5 - 1.0 normalises down
    expect_result(32'h3F00_0000, 16'd2);
    send(32'h3FC0_0000, 1'b0, 1'b1);
    send(32'hBF80_0000, 1'b1, 1'b1);
    collect();

    // Overflow saturates to +inf
    expect_result(32'h7F80_0000, 16'd2);
    send(32'h7F7F_FFFF, 1'b0, 1'b1);
    send(32'h7F7F_FFFF, 1'b1, 1'b1);
    collect();

    // inf + -inf -> qNaN (special path, untimed)
    expect_result(32'h7FC0_0000, 16'd2);
    send(32'h7F80_0000, 1'b0, 1'b0);
    send(32'hFF80_0000, 1'b1, 1'b0);
    collect();

    // Subnormal flushes to +0
    expect_result(32'h0000_0000, 16'd1);
    send(32'h0000_0001, 1'b1, 1'b1);
    collect();

    // Backpressure in DONE with ignored input pulses
    expect_result(32'h4000_0000, 16'd1);
    send(32'h4000_0000, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F80_0000;
      bus.in_last  = 1'b1;
      @(negedge clk);
      check32("bp_out_data", bus.out_data, 32'h4000_0000);
      check32("bp_out_count", 32'(bus.out_count), 32'd1);
      check32("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check32("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    collect();
    expect_result(32'h3F80_0000, 16'd1);
    send(32'h3F80_0000, 1'b1, 1'b1);
    collect();

    // Reset during ADD discards the partial sum
    send(32'h4000_0000, 1'b0, 1'b1);
    send(32'h4080_0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check32("pre_rst_state", 32'(state), 32'(ADD));
    rst = 1'b1;
    #1;
    check32("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check32("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check32("mid_rst_out_data", bus.out_data, 32'h0);
    check32("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    check32("mid_rst_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    expect_result(32'h3F80_0000, 16'd1);
    send(32'h3F80_0000, 1'b1, 1'b1);
    collect();

    check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
